// File: rtl/bbox_scan_ctrl.sv
// Raster-scans a WIDTH x HEIGHT pixel RAM and reports the bounding box of
// every pixel at or above a latched threshold.
module bbox_scan_ctrl #(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100,
  parameter int ADDR_W = 14,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [PIX_W-1:0]  threshold,
  output logic              rdy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rden,
  input  logic [PIX_W-1:0]  mem_rddata,
  output logic [10:0]       x_min,
  output logic [10:0]       x_max,
  output logic [10:0]       y_min,
  output logic [10:0]       y_max,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [10:0] X_LAST = 11'(WIDTH - 1);
  localparam logic [10:0] Y_LAST = 11'(HEIGHT - 1);

  logic [1:0]        state_q, state_d;
  logic [PIX_W-1:0]  thr_q, thr_d;
  logic [10:0]       x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Coordinates of the read issued last cycle, aligned with returning data.
  logic              vld_q, vld_d;
  logic [10:0]       px_q, px_d, py_q, py_d;

  logic [10:0]       acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
  logic [10:0]       acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
  logic              hit_q, hit_d;

  logic              found_q, found_d;
  logic [10:0]       xmin_q, xmin_d, xmax_q, xmax_d;
  logic [10:0]       ymin_q, ymin_d, ymax_q, ymax_d;

  logic              scan_last;
  logic              pix_hit;

  assign scan_last = (x_q == X_LAST) && (y_q == Y_LAST);
  assign pix_hit   = vld_q && (mem_rddata >= thr_q);

  always_comb begin
    state_d    = state_q;
    thr_d      = thr_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    vld_d      = 1'b0;
    px_d       = x_q;
    py_d       = y_q;
    acc_xmin_d = acc_xmin_q;
    acc_xmax_d = acc_xmax_q;
    acc_ymin_d = acc_ymin_q;
    acc_ymax_d = acc_ymax_q;
    hit_d      = hit_q;
    found_d    = found_q;
    xmin_d     = xmin_q;
    xmax_d     = xmax_q;
    ymin_d     = ymin_q;
    ymax_d     = ymax_q;

    if (pix_hit) begin
      if (px_q < acc_xmin_q) acc_xmin_d = px_q;
      if (px_q > acc_xmax_q) acc_xmax_d = px_q;
      if (py_q < acc_ymin_q) acc_ymin_d = py_q;
      if (py_q > acc_ymax_q) acc_ymax_d = py_q;
      hit_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SCAN;
          thr_d      = threshold;
          x_d        = '0;
          y_d        = '0;
          addr_d     = '0;
          acc_xmin_d = '1;
          acc_xmax_d = '0;
          acc_ymin_d = '1;
          acc_ymax_d = '0;
          hit_d      = 1'b0;
        end
      end
      S_SCAN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          vld_d = 1'b1;
          if (scan_last) begin
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + 11'd1;
            end else begin
              x_d = x_q + 11'd1;
            end
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          // The final pixel is evaluated this cycle, so publish the
          // accumulators including its contribution.
          state_d = S_DONE;
          found_d = hit_d;
          if (hit_d) begin
            xmin_d = acc_xmin_d;
            xmax_d = acc_xmax_d;
            ymin_d = acc_ymin_d;
            ymax_d = acc_ymax_d;
          end else begin
            xmin_d = '0;
            xmax_d = '0;
            ymin_d = '0;
            ymax_d = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      thr_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      vld_q      <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      acc_xmin_q <= '1;
      acc_xmax_q <= '0;
      acc_ymin_q <= '1;
      acc_ymax_q <= '0;
      hit_q      <= 1'b0;
      found_q    <= 1'b0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymin_q     <= '0;
      ymax_q     <= '0;
    end else begin
      state_q    <= state_d;
      thr_q      <= thr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      vld_q      <= vld_d;
      px_q       <= px_d;
      py_q       <= py_d;
      acc_xmin_q <= acc_xmin_d;
      acc_xmax_q <= acc_xmax_d;
      acc_ymin_q <= acc_ymin_d;
      acc_ymax_q <= acc_ymax_d;
      hit_q      <= hit_d;
      found_q    <= found_d;
      xmin_q     <= xmin_d;
      xmax_q     <= xmax_d;
      ymin_q     <= ymin_d;
      ymax_q     <= ymax_d;
    end
  end

  assign rdy       = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_rden  = (state_q == S_SCAN);
  assign mem_addr  = addr_q;
  assign found     = found_q;
  assign x_min     = xmin_q;
  assign x_max     = xmax_q;
  assign y_min     = ymin_q;
  assign y_max     = ymax_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bbox_scan_ctrl.sv
// Bench for bbox_scan_ctrl on a 4x3 image: a small RAM model, a reference
// bounding-box model feeding an expected-result queue, and timing checks.
module tb_bbox_scan_ctrl;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  threshold = 8'd0;
  logic        rdy, done, found, mem_rden;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_rddata;
  logic [10:0] x_min, x_max, y_min, y_max;
  logic [1:0]  dbg_state;

  logic [7:0]  img [0:15];
  logic [7:0]  rd_q;
  logic [44:0] exp_q [$];
  logic [44:0] last_exp;
  int          n_checks = 0;
  int          n_fails = 0;

  bbox_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(4), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .threshold(threshold),
    .rdy(rdy), .done(done), .found(found), .mem_addr(mem_addr),
    .mem_rden(mem_rden), .mem_rddata(mem_rddata),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .dbg_state(dbg_state)
  );

  // clock / RAM model: data valid exactly one cycle after the read
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rden) rd_q <= img[mem_addr];
  assign mem_rddata = rd_q;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [44:0] model(input logic [7:0] thr);
    logic [10:0] xmn, xmx, ymn, ymx;
    logic        f;
    xmn = 11'h7ff; xmx = 0; ymn = 11'h7ff; ymx = 0; f = 1'b0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (img[y*W + x] >= thr) begin
          f = 1'b1;
          if (11'(x) < xmn) xmn = 11'(x);
          if (11'(x) > xmx) xmx = 11'(x);
          if (11'(y) < ymn) ymn = 11'(y);
          if (11'(y) > ymx) ymx = 11'(y);
        end
    if (!f) return '0;
    return {f, xmn, xmx, ymn, ymx};
  endfunction

  function automatic logic [44:0] outs();
    return {found, x_min, x_max, y_min, y_max};
  endfunction

  // scoreboard: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() > 0) check("result", 64'(outs()), 64'(exp_q.pop_front()));
      else check("unexpected_done", 64'(done), 64'(0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 8'd0;
  endtask

  // Full scan from IDLE with exact cycle/address checks.
  task automatic run_scan(input logic [7:0] thr);
    logic [44:0] e;
    e = model(thr);
    exp_q.push_back(e);
    threshold = thr;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= N; k++) begin
      check("rden_scan", 64'(mem_rden), 64'(1));
      check("addr_seq", 64'(mem_addr), 64'(k - 1));
      check("hold_prev", 64'(outs()), 64'(last_exp));
      step();
    end
    check("rden_drain", 64'(mem_rden), 64'(0));
    check("addr_hold", 64'(mem_addr), 64'(N - 1));
    check("done_early", 64'(done), 64'(0));
    step();
    check("done_at_n2", 64'(done), 64'(1));
    check("rdy_in_done", 64'(rdy), 64'(0));
    step();
    check("rdy_after", 64'(rdy), 64'(1));
    check("done_1cyc", 64'(done), 64'(0));
    check("result_hold", 64'(outs()), 64'(e));
    last_exp = e;
  endtask

  initial begin
    last_exp = '0;
    clear_img();
    step();
    step();
    check("rst_rdy", 64'(rdy), 64'(1));
    check("rst_done", 64'(done), 64'(0));
    check("rst_rden", 64'(mem_rden), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_outs", 64'(outs()), 64'(0));
    rst = 1'b0;
    step();

    // single hit at (2,1)
    img[1*W + 2] = 8'd200;
    run_scan(8'd128);
    check("t1_found", 64'(found), 64'(1));

    // no hits
    clear_img();
    run_scan(8'd128);

    // corner hits with threshold equality
    img[0] = 8'd255;
    img[N-1] = 8'd255;
    run_scan(8'd255);

    // random images and thresholds
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
      run_scan(8'($urandom_range(100, 255)));
      step();
    end

    // abort during SCAN at cycle 5
    threshold = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    check("abort_hold", 64'(outs()), 64'(last_exp));
    step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_rdy", 64'(rdy), 64'(1));
    check("abort_rden", 64'(mem_rden), 64'(0));
    check("abort_outs", 64'(outs()), 64'(last_exp));
    for (int i = 0; i < 20; i++) step();
    check("abort_no_done", 64'(exp_q.size()), 64'(0));

    // abort ignored in IDLE
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", 64'(rdy), 64'(1));

    // asynchronous reset mid-SCAN
    clear_img();
    img[5] = 8'd250;
    run_scan(8'd10);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    check("arst_rdy", 64'(rdy), 64'(1));
    check("arst_rden", 64'(mem_rden), 64'(0));
    check("arst_addr", 64'(mem_addr), 64'(0));
    check("arst_outs", 64'(outs()), 64'(0));
    rst = 1'b0;
    last_exp = '0;
    step();

    // start held high: done every 15 cycles, start ignored while busy
    clear_img();
    img[3] = 8'd140;
    img[8] = 8'd130;
    threshold = 8'd128;
    for (int i = 0; i < 3; i++) exp_q.push_back(model(8'd128));
    start = 1'b1;
    step();
    for (int k = 1; k <= 44; k++) begin
      check("b2b_done", 64'(done), 64'((k == 14) || (k == 29) || (k == 44)));
      check("b2b_rdy", 64'(rdy), 64'((k == 15) || (k == 30)));
      if (k == 44) start = 1'b0;
      step();
    end
    check("b2b_idle", 64'(rdy), 64'(1));
    for (int i = 0; i < 5; i++) step();
    check("b2b_drained", 64'(exp_q.size()), 64'(0));
    check("b2b_result", 64'(outs()), 64'(model(8'd128)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
